// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, TX FSM states and the baud divisor helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud);
        return clk / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data is visible combinationally at the head.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // The pointer MSB is the wrap bit: equal pointers mean empty, MSB-only difference means full.
    assign level    = wr_ptr_q - rd_ptr_q;
    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with valid/ready input FIFO and back-to-back framing.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           sys_clk,
    input  logic                           rst_n,
    input  logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    output logic                           tx,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned BW       = $clog2(BAUD_DIV);
    localparam int unsigned CW       = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [BW-1:0]        baud_cnt_q, baud_cnt_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 pending_q, pending_d;

    logic                 fifo_full, fifo_empty, fifo_pop, load, bit_end;
    logic [DATA_BITS-1:0] fifo_rd_data;

    assign tx_ready = !fifo_full;
    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE) || (fifo_level != '0);
    assign bit_end  = (baud_cnt_q == BAUD_LAST);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .push      (tx_valid && tx_ready),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        par_d      = par_q;
        load       = 1'b0;
        fifo_pop   = 1'b0;
        // IDLE acts on a registered not-empty flag, so a word written at edge N starts at N+2.
        pending_d  = !fifo_empty;

        if (state_q != ST_IDLE) baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (pending_q && !fifo_empty) load = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    sh_d = sh_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        if (!fifo_empty) load = 1'b1;
                        else             state_d = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            fifo_pop   = 1'b1;
            sh_d       = fifo_rd_data;
            par_d      = (PARITY == PAR_EVEN) ? ^fifo_rd_data : ~^fifo_rd_data;
            bit_cnt_d  = '0;
            baud_cnt_d = '0;
            state_d    = ST_START;
        end

        // Line level follows the next state so tx changes on the same edge as the state.
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = sh_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            pending_q  <= pending_d;
        end
    end

endmodule
